// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arb_pkg
//  Description : Shared types and constants for the ALU request arbiter:
//                FSM state encoding, functional-unit select codes and the
//                response data width.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

    // Arbiter control states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_CAPT = 2'd2,
        S_RESP = 2'd3
    } arb_state_e;

    // Functional-unit select carried in fun[3:2]
    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    localparam int ALU_WIDTH_DEF = 16;
    localparam int RSP_W         = 2 * ALU_WIDTH_DEF + 1;

    // Response width for an arbitrary operand width (full signed product + 1)
    function automatic int rsp_width(input int width);
        return 2 * width + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ALU_TOP.sv
`default_nettype none
// ============================================================================
//  Module      : ALU_TOP
//  Description : Four-unit ALU with registered outputs. Every unit evaluates
//                the op code in parallel; the caller picks the unit it wants.
//                  arith : add, sub, signed mul, negate a   (2*WIDTH+1 bits)
//                  logic : and, or, xor, not a
//                  cmp   : eq, signed lt, signed gt, unsigned lt (result in bit 0)
//                  shift : sll, srl, sra, rotate-left by b[log2(WIDTH)-1:0]
//                Flags: compare flag is the comparison outcome; all other
//                units flag a non-zero result.
//  Revision    : 1.0 - initial release
// ============================================================================
module ALU_TOP #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [1:0]         i_op,
    output logic [2*WIDTH:0]   o_arith,
    output logic               o_arith_flag,
    output logic [WIDTH-1:0]   o_logic,
    output logic               o_logic_flag,
    output logic [WIDTH-1:0]   o_cmp,
    output logic               o_cmp_flag,
    output logic [WIDTH-1:0]   o_shift,
    output logic               o_shift_flag
);

    localparam int c_SH_W = $clog2(WIDTH);

    logic signed [2*WIDTH:0]   w_a_ext;
    logic signed [2*WIDTH:0]   w_b_ext;
    logic signed [2*WIDTH:0]   w_arith;
    logic        [WIDTH-1:0]   w_logic;
    logic                      w_cond;
    logic        [WIDTH-1:0]   w_shift;
    logic        [c_SH_W-1:0]  w_sh;
    logic signed [WIDTH-1:0]   w_a_s;
    logic        [2*WIDTH-1:0] w_dbl;

    assign w_a_ext = {{(WIDTH + 1){i_a[WIDTH-1]}}, i_a};
    assign w_b_ext = {{(WIDTH + 1){i_b[WIDTH-1]}}, i_b};
    assign w_sh    = i_b[c_SH_W-1:0];
    assign w_a_s   = i_a;
    assign w_dbl   = {i_a, i_a} << w_sh;

    // Per-unit combinational results for the current op code
    always_comb begin
        w_arith = '0;
        w_logic = '0;
        w_cond  = 1'b0;
        w_shift = '0;
        case (i_op)
            2'b00: begin
                w_arith = w_a_ext + w_b_ext;
                w_logic = i_a & i_b;
                w_cond  = (i_a == i_b);
                w_shift = i_a << w_sh;
            end
            2'b01: begin
                w_arith = w_a_ext - w_b_ext;
                w_logic = i_a | i_b;
                w_cond  = ($signed(i_a) < $signed(i_b));
                w_shift = i_a >> w_sh;
            end
            2'b10: begin
                w_arith = w_a_ext * w_b_ext;
                w_logic = i_a ^ i_b;
                w_cond  = ($signed(i_a) > $signed(i_b));
                w_shift = w_a_s >>> w_sh;
            end
            default: begin
                w_arith = -w_a_ext;
                w_logic = ~i_a;
                w_cond  = (i_a < i_b);
                w_shift = w_dbl[2*WIDTH-1:WIDTH];
            end
        endcase
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            o_arith      <= '0;
            o_arith_flag <= 1'b0;
            o_logic      <= '0;
            o_logic_flag <= 1'b0;
            o_cmp        <= '0;
            o_cmp_flag   <= 1'b0;
            o_shift      <= '0;
            o_shift_flag <= 1'b0;
        end else begin
            o_arith      <= w_arith;
            o_arith_flag <= (w_arith != '0);
            o_logic      <= w_logic;
            o_logic_flag <= (w_logic != '0);
            o_cmp        <= {{(WIDTH - 1){1'b0}}, w_cond};
            o_cmp_flag   <= w_cond;
            o_shift      <= w_shift;
            o_shift_flag <= (w_shift != '0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rr_arb2
//  Description : Two-way combinational round-robin arbiter. With both ports
//                requesting, the port that was not granted last wins. The
//                last-grant state is held by the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant: port 0 wins unless port 1 also requests and port 0 went last
    always_comb begin
        grant = 2'b00;
        if (req[0] && (!req[1] || last_grant)) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one ALU_TOP between two valid/ready requesters.
//                Round-robin grant, ALU operand registers, wait for the ALU
//                output register, capture of the unit addressed by fun[3:2]
//                and a held valid/ready response tagged with the requester.
//                Optional macro ALU_ARB_BACK2BACK_EN lets the response
//                handshake cycle accept the next request directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic               req1_valid,
    output logic               req0_ready,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    input  logic [3:0]         req0_fun,
    input  logic [3:0]         req1_fun,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [2*WIDTH:0]   rsp_data,
    output logic               rsp_flag,
    output logic               busy
);

    localparam int c_RSP_W = rsp_width(WIDTH);

    arb_state_e          r_state;
    logic [WIDTH-1:0]    r_alu_a;
    logic [WIDTH-1:0]    r_alu_b;
    logic [3:0]          r_alu_fun;
    logic                r_id;
    logic                r_last_grant;

    logic [1:0]          w_req;
    logic [1:0]          w_grant;
    logic [1:0]          w_take;
    logic                w_accept_ok;

    logic [c_RSP_W-1:0]  w_arith;
    logic                w_arith_flag;
    logic [WIDTH-1:0]    w_logic;
    logic                w_logic_flag;
    logic [WIDTH-1:0]    w_cmp;
    logic                w_cmp_flag;
    logic [WIDTH-1:0]    w_shift;
    logic                w_shift_flag;
    logic [c_RSP_W-1:0]  w_sel_data;
    logic                w_sel_flag;

    assign w_req = {req1_valid, req0_valid};

    alu_rr_arb2 u_arb (
        .req        (w_req),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

`ifdef ALU_ARB_BACK2BACK_EN
    // A completing response frees the ALU, so the same cycle may accept
    assign w_accept_ok = !rst && ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready));
`else
    assign w_accept_ok = !rst && (r_state == S_IDLE);
`endif

    assign w_take     = w_accept_ok ? w_grant : 2'b00;
    assign req0_ready = w_take[0];
    assign req1_ready = w_take[1];

    ALU_TOP #(
        .WIDTH (WIDTH)
    ) u_alu (
        .clk          (clk),
        .rst          (rst),
        .i_a          (r_alu_a),
        .i_b          (r_alu_b),
        .i_op         (r_alu_fun[1:0]),
        .o_arith      (w_arith),
        .o_arith_flag (w_arith_flag),
        .o_logic      (w_logic),
        .o_logic_flag (w_logic_flag),
        .o_cmp        (w_cmp),
        .o_cmp_flag   (w_cmp_flag),
        .o_shift      (w_shift),
        .o_shift_flag (w_shift_flag)
    );

    // Pick the registered result of the unit addressed by the latched function
    always_comb begin
        w_sel_data = w_arith;
        w_sel_flag = w_arith_flag;
        case (r_alu_fun[3:2])
            UNIT_LOGIC: begin
                w_sel_data = {{(c_RSP_W - WIDTH){1'b0}}, w_logic};
                w_sel_flag = w_logic_flag;
            end
            UNIT_CMP: begin
                w_sel_data = {{(c_RSP_W - WIDTH){1'b0}}, w_cmp};
                w_sel_flag = w_cmp_flag;
            end
            UNIT_SHIFT: begin
                w_sel_data = {{(c_RSP_W - WIDTH){1'b0}}, w_shift};
                w_sel_flag = w_shift_flag;
            end
            default: begin
                w_sel_data = w_arith;
                w_sel_flag = w_arith_flag;
            end
        endcase
    end

    // Control FSM: accept, let the ALU register stage fill, capture, hold response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_fun    <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_data     <= '0;
            rsp_flag     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // Operand registers only change on a grant and hold otherwise
            if (w_take != 2'b00) begin
                r_alu_a      <= w_take[1] ? req1_a   : req0_a;
                r_alu_b      <= w_take[1] ? req1_b   : req0_b;
                r_alu_fun    <= w_take[1] ? req1_fun : req0_fun;
                r_id         <= w_take[1];
                r_last_grant <= w_take[1];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_take != 2'b00) begin
                        r_state <= S_EXEC;
                        busy    <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    rsp_data  <= w_sel_data;
                    rsp_flag  <= w_sel_flag;
                    rsp_id    <= r_id;
                    rsp_valid <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (w_take != 2'b00) begin
                            r_state <= S_EXEC;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter. Directed scenarios plus
//                randomized traffic checked against a behavioural model of the
//                ALU units and the round-robin rule.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic          req1_valid = 1'b0;
    logic          req0_ready;
    logic          req1_ready;
    logic [W-1:0]  req0_a = '0;
    logic [W-1:0]  req0_b = '0;
    logic [W-1:0]  req1_a = '0;
    logic [W-1:0]  req1_b = '0;
    logic [3:0]    req0_fun = '0;
    logic [3:0]    req1_fun = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_id;
    logic [2*W:0]  rsp_data;
    logic          rsp_flag;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;
    bit exp_last = 1'b1;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_fun   (req0_fun),
        .req1_fun   (req1_fun),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_flag   (rsp_flag),
        .busy       (busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural ALU: returns {flag, 33-bit response data}
    function automatic logic [33:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] f);
        longint      sa, sb, r;
        int          sh;
        logic [31:0] t;
        logic [15:0] u;
        logic [32:0] d;
        logic        c;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[3:0]);
        t  = {16'd0, a} << sh;
        u  = '0;
        c  = 1'b0;
        r  = 0;
        case (f[3:2])
            2'b00: begin
                case (f[1:0])
                    2'd0:    r = sa + sb;
                    2'd1:    r = sa - sb;
                    2'd2:    r = sa * sb;
                    default: r = -sa;
                endcase
                d = r[32:0];
                return {d != 33'd0, d};
            end
            2'b01: begin
                case (f[1:0])
                    2'd0:    u = a & b;
                    2'd1:    u = a | b;
                    2'd2:    u = a ^ b;
                    default: u = ~a;
                endcase
                return {u != 16'd0, 17'd0, u};
            end
            2'b10: begin
                case (f[1:0])
                    2'd0:    c = (a == b);
                    2'd1:    c = (sa < sb);
                    2'd2:    c = (sa > sb);
                    default: c = (a < b);
                endcase
                return {c, 32'd0, c};
            end
            default: begin
                case (f[1:0])
                    2'd0:    u = t[15:0];
                    2'd1:    u = a >> sh;
                    2'd2:    begin r = sa >>> sh; u = r[15:0]; end
                    default: u = t[15:0] | t[31:16];
                endcase
                return {u != 16'd0, 17'd0, u};
            end
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_last = 1'b1;
    endtask

    // One full transaction from IDLE back to IDLE, with 'stall' cycles of rsp_ready low
    task automatic do_txn(input bit v0, input bit v1,
                          input logic [15:0] a0, input logic [15:0] b0, input logic [3:0] f0,
                          input logic [15:0] a1, input logic [15:0] b1, input logic [3:0] f1,
                          input int stall);
        int          win;
        logic [33:0] e;
        req0_a = a0; req0_b = b0; req0_fun = f0;
        req1_a = a1; req1_b = b1; req1_fun = f1;
        req0_valid = v0;
        req1_valid = v1;
        rsp_ready  = 1'b0;
        if (!v0 && !v1) begin
            #1;
            chk("idle_no_ready", {req1_ready, req0_ready}, 2'b00);
            tick();
            chk("idle_stays", busy, 1'b0);
            return;
        end
        win = (v0 && v1) ? (exp_last ? 0 : 1) : (v1 ? 1 : 0);
        e   = win ? ref_alu(a1, b1, f1) : ref_alu(a0, b0, f0);
        #1;
        chk("grant", {req1_ready, req0_ready}, (win == 1) ? 2'b10 : 2'b01);
        exp_last = (win == 1);
        tick();
        // EXEC and CAPT: other traffic and operand churn must be ignored
        for (int c = 0; c < 2; c++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_a = W'($urandom); req1_a = W'($urandom);
            req0_b = W'($urandom); req1_b = W'($urandom);
            rsp_ready = 1'($urandom);
            #1;
            chk("busy_no_ready", {req1_ready, req0_ready}, 2'b00);
            chk("busy_high", busy, 1'b1);
            chk("early_valid", rsp_valid, 1'b0);
            tick();
        end
        rsp_ready = 1'b0;
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_data", rsp_data, e[32:0]);
        chk("rsp_flag", rsp_flag, e[33]);
        chk("rsp_id", rsp_id, win[0]);
        for (int s = 0; s < stall; s++) begin
            #1;
            chk("stall_no_ready", {req1_ready, req0_ready}, 2'b00);
            tick();
            chk("stall_valid", rsp_valid, 1'b1);
            chk("stall_data", rsp_data, e[32:0]);
            chk("stall_id", rsp_id, win[0]);
        end
`ifdef ALU_ARB_BACK2BACK_EN
        req0_valid = 1'b0;
        req1_valid = 1'b0;
`else
        req0_valid = 1'b1;
        req1_valid = 1'b1;
`endif
        rsp_ready = 1'b1;
        #1;
        chk("resp_no_ready", {req1_ready, req0_ready}, 2'b00);
        tick();
        chk("after_hs_valid", rsp_valid, 1'b0);
        chk("after_hs_busy", busy, 1'b0);
        rsp_ready  = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        logic [33:0] e1;
        logic [33:0] e2;
        bit          seen;

        // Reset state, with a request present during reset
        req0_valid = 1'b1;
        #1;
        chk("ready_in_reset", {req1_ready, req0_ready}, 2'b00);
        tick();
        tick();
        req0_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_data", rsp_data, 33'd0);
        chk("rst_id", rsp_id, 1'b0);
        chk("rst_flag", rsp_flag, 1'b0);
        tick();

        // Single add on port 0
        do_txn(1'b1, 1'b0, 16'd5, 16'd3, 4'b0000, 16'd0, 16'd0, 4'b0000, 0);

        // Contention straight after reset: 0, then 1, then 0 again
        do_reset();
        do_txn(1'b1, 1'b1, 16'd1, 16'd1, 4'b0000, 16'd2, 16'd2, 4'b0000, 0);
        do_txn(1'b1, 1'b1, 16'd1, 16'd1, 4'b0000, 16'd2, 16'd2, 4'b0000, 0);
        do_txn(1'b1, 1'b1, 16'd1, 16'd1, 4'b0000, 16'd2, 16'd2, 4'b0000, 0);

        // Response stall of 5 cycles
        do_txn(1'b0, 1'b1, 16'd0, 16'd0, 4'b0000, 16'hFFFF, 16'd7, 4'b0010, 5);

        // Logic AND on port 1
        do_txn(1'b0, 1'b1, 16'd0, 16'd0, 4'b0000, 16'hF0F0, 16'h0FF0, 4'b0100, 1);

        // Reset while in CAPT drops the request
        req0_a = 16'd7; req0_b = 16'd9; req0_fun = 4'b0000;
        req0_valid = 1'b1;
        #1;
        chk("midrst_grant", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_valid", rsp_valid, 1'b0);
        chk("midrst_data", rsp_data, 33'd0);
        rst = 1'b0;
        exp_last = 1'b1;
        rsp_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        chk("midrst_no_rsp", seen, 1'b0);
        rsp_ready = 1'b0;

`ifdef ALU_ARB_BACK2BACK_EN
        // Two queued port-0 requests; second accepted on the first handshake
        e1 = ref_alu(16'd100, 16'd23, 4'b0001);
        e2 = ref_alu(16'h00FF, 16'd4, 4'b1100);
        req0_a = 16'd100; req0_b = 16'd23; req0_fun = 4'b0001;
        req0_valid = 1'b1;
        rsp_ready  = 1'b1;
        #1;
        chk("b2b_first_grant", req0_ready, 1'b1);
        tick();
        req0_a = 16'h00FF; req0_b = 16'd4; req0_fun = 4'b1100;
        #1;
        chk("b2b_exec_no_ready", req0_ready, 1'b0);
        tick();
        tick();
        chk("b2b_rsp1_valid", rsp_valid, 1'b1);
        chk("b2b_rsp1_data", rsp_data, e1[32:0]);
        #1;
        chk("b2b_second_grant", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        chk("b2b_gap_valid", rsp_valid, 1'b0);
        chk("b2b_gap_busy", busy, 1'b1);
        tick();
        chk("b2b_capt_valid", rsp_valid, 1'b0);
        tick();
        chk("b2b_rsp2_valid", rsp_valid, 1'b1);
        chk("b2b_rsp2_data", rsp_data, e2[32:0]);
        chk("b2b_rsp2_flag", rsp_flag, e2[33]);
        tick();
        chk("b2b_idle", busy, 1'b0);
        rsp_ready = 1'b0;
        exp_last = 1'b0;
`else
        e1 = '0;
        e2 = '0;
`endif

        // Randomized traffic
        for (int i = 0; i < 48; i++) begin
            do_txn(1'($urandom), 1'($urandom),
                   W'($urandom), W'($urandom), 4'($urandom),
                   W'($urandom), W'($urandom), 4'($urandom),
                   int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
